// File: rtl/clause_loader.sv
// clause_loader: receiving end of the host clause-load stream.
// Validates signed DIMACS literals, writes them into the solver literal
// memory, writes one (start, length) clause-table entry per clause and
// gates the solve-start request towards the DPLL core.
module clause_loader #(
  parameter int MAX_VARS       = 256,
  parameter int MAX_CLAUSES    = 256,
  parameter int MAX_LITS       = 2048,
  parameter int MAX_CLAUSE_LEN = 16,
  localparam int VW  = $clog2(MAX_VARS),
  localparam int LAW = $clog2(MAX_LITS),
  localparam int CAW = $clog2(MAX_CLAUSES),
  localparam int LNW = $clog2(MAX_CLAUSE_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load_valid,
  input  logic signed [31:0] load_literal,
  input  logic               load_clause_end,
  output logic               load_ready,
  input  logic               start_solve,
  output logic               lit_wr_en,
  output logic [LAW-1:0]     lit_wr_addr,
  output logic [VW:0]        lit_wr_data,
  output logic               cls_wr_en,
  output logic [CAW-1:0]     cls_wr_addr,
  output logic [LAW-1:0]     cls_wr_start,
  output logic [LNW-1:0]     cls_wr_len,
  output logic [CAW:0]       num_clauses,
  output logic [LAW:0]       num_lits,
  output logic [VW:0]        max_var,
  output logic               solve_go,
  output logic               load_error,
  output logic [2:0]         error_code
);

  typedef enum logic [1:0] {
    S_INIT,
    S_LOAD,
    S_LOCKED,
    S_ERROR
  } state_t;

  localparam logic [LAW:0]   LITS_FULL = (LAW+1)'(MAX_LITS);
  localparam logic [CAW:0]   CLS_FULL  = (CAW+1)'(MAX_CLAUSES);
  localparam logic [LNW-1:0] LEN_FULL  = LNW'(MAX_CLAUSE_LEN);
  localparam logic [31:0]    VAR_LIMIT = 32'(MAX_VARS);

  localparam logic [2:0] E_NONE      = 3'd0;
  localparam logic [2:0] E_ZERO      = 3'd1;
  localparam logic [2:0] E_RANGE     = 3'd2;
  localparam logic [2:0] E_LITS_FULL = 3'd3;
  localparam logic [2:0] E_CLS_FULL  = 3'd4;
  localparam logic [2:0] E_TOO_LONG  = 3'd5;
  localparam logic [2:0] E_OPEN      = 3'd6;
  localparam logic [2:0] E_EMPTY     = 3'd7;

  state_t state, state_n;

  logic [LNW-1:0] cur_len;
  logic [LAW-1:0] base;

  logic           xfer;
  logic           accept;
  logic           commit;
  logic           go;
  logic [2:0]     err_n;
  logic [31:0]    mag;
  logic [LNW-1:0] len_after;
  logic [CAW:0]   cls_after;

  // Magnitude of a 32-bit two's-complement literal; -2^31 yields 2^31,
  // which is far above any legal variable index.
  function automatic logic [31:0] lit_mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Clamp a magnitude into the max_var range.
  function automatic logic [VW:0] sat_var(input logic [31:0] m);
    return (m > VAR_LIMIT) ? VAR_LIMIT[VW:0] : m[VW:0];
  endfunction

  // Zero-based variable index stored in literal memory.
  function automatic logic [VW-1:0] var_index(input logic [31:0] m);
    return VW'(m - 32'd1);
  endfunction

  function automatic logic [VW:0] var_max(input logic [VW:0] a, input logic [VW:0] b);
    return (a > b) ? a : b;
  endfunction

  assign mag = lit_mag(load_literal);

  // Next state, validation and write decisions for the current cycle.
  always_comb begin
    state_n    = state;
    load_ready = 1'b0;
    xfer       = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    go         = 1'b0;
    err_n      = E_NONE;
    len_after  = cur_len;
    cls_after  = num_clauses;
    case (state)
      S_INIT: state_n = S_LOAD;
      S_LOAD: begin
        load_ready = 1'b1;
        xfer       = load_valid;
        if (xfer) begin
          if (load_literal == 32'sd0)                          err_n = E_ZERO;
          else if (mag > VAR_LIMIT)                            err_n = E_RANGE;
          else if (num_lits == LITS_FULL)                      err_n = E_LITS_FULL;
          else if (load_clause_end && num_clauses == CLS_FULL) err_n = E_CLS_FULL;
          else if (cur_len == LEN_FULL)                        err_n = E_TOO_LONG;
          if (load_clause_end) begin
            len_after = '0;
            cls_after = num_clauses + (CAW+1)'(1);
          end else begin
            len_after = cur_len + LNW'(1);
          end
        end
        // start is judged against the problem as it stands after this
        // cycle's literal, so a final literal plus start is legal
        if (err_n == E_NONE && start_solve) begin
          if (len_after != '0)     err_n = E_OPEN;
          else if (cls_after == 0) err_n = E_EMPTY;
          else                     go    = 1'b1;
        end
        // an erroring cycle never writes anything
        accept = xfer && (err_n == E_NONE);
        commit = accept && load_clause_end;
        if (err_n != E_NONE) state_n = S_ERROR;
        else if (go)         state_n = S_LOCKED;
      end
      default: state_n = state;
    endcase
  end

  // Registered writes, counters and status; rst and clear discard everything.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state        <= S_INIT;
      cur_len      <= '0;
      base         <= '0;
      lit_wr_en    <= 1'b0;
      lit_wr_addr  <= '0;
      lit_wr_data  <= '0;
      cls_wr_en    <= 1'b0;
      cls_wr_addr  <= '0;
      cls_wr_start <= '0;
      cls_wr_len   <= '0;
      num_clauses  <= '0;
      num_lits     <= '0;
      max_var      <= '0;
      solve_go     <= 1'b0;
      load_error   <= 1'b0;
      error_code   <= '0;
    end else begin
      state     <= state_n;
      lit_wr_en <= accept;
      cls_wr_en <= commit;
      solve_go  <= go;
      if (accept) begin
        lit_wr_addr <= num_lits[LAW-1:0];
        lit_wr_data <= {load_literal[31], var_index(mag)};
        num_lits    <= num_lits + (LAW+1)'(1);
        max_var     <= var_max(max_var, sat_var(mag));
        if (commit) begin
          cls_wr_addr  <= num_clauses[CAW-1:0];
          cls_wr_start <= base;
          cls_wr_len   <= cur_len + LNW'(1);
          num_clauses  <= num_clauses + (CAW+1)'(1);
          base         <= LAW'(num_lits + (LAW+1)'(1));
          cur_len      <= '0;
        end else begin
          cur_len <= cur_len + LNW'(1);
        end
      end
      if (err_n != E_NONE) begin
        load_error <= 1'b1;
        error_code <= err_n;
      end
    end
  end

endmodule

// File: tb/tb_clause_loader.sv
// Directed bench for clause_loader with hand-computed expected values.
module tb_clause_loader;

  localparam int VW  = 8;
  localparam int LAW = 11;
  localparam int CAW = 8;
  localparam int LNW = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               load_valid;
  logic signed [31:0] load_literal;
  logic               load_clause_end;
  logic               load_ready;
  logic               start_solve;
  logic               lit_wr_en;
  logic [LAW-1:0]     lit_wr_addr;
  logic [VW:0]        lit_wr_data;
  logic               cls_wr_en;
  logic [CAW-1:0]     cls_wr_addr;
  logic [LAW-1:0]     cls_wr_start;
  logic [LNW-1:0]     cls_wr_len;
  logic [CAW:0]       num_clauses;
  logic [LAW:0]       num_lits;
  logic [VW:0]        max_var;
  logic               solve_go;
  logic               load_error;
  logic [2:0]         error_code;

  int n_checks = 0;
  int n_errors = 0;

  clause_loader dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .load_valid      (load_valid),
    .load_literal    (load_literal),
    .load_clause_end (load_clause_end),
    .load_ready      (load_ready),
    .start_solve     (start_solve),
    .lit_wr_en       (lit_wr_en),
    .lit_wr_addr     (lit_wr_addr),
    .lit_wr_data     (lit_wr_data),
    .cls_wr_en       (cls_wr_en),
    .cls_wr_addr     (cls_wr_addr),
    .cls_wr_start    (cls_wr_start),
    .cls_wr_len      (cls_wr_len),
    .num_clauses     (num_clauses),
    .num_lits        (num_lits),
    .max_var         (max_var),
    .solve_go        (solve_go),
    .load_error      (load_error),
    .error_code      (error_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [31:0] lit, input logic ce);
    load_valid      = 1'b1;
    load_literal    = lit;
    load_clause_end = ce;
    step();
    load_valid      = 1'b0;
    load_clause_end = 1'b0;
    load_literal    = '0;
  endtask

  task automatic send_chk(input string tag, input logic signed [31:0] lit, input logic ce,
                          input int exp_addr, input logic [VW:0] exp_data);
    send(lit, ce);
    check({tag, "_en"}, 32'(lit_wr_en), 32'd1);
    check({tag, "_addr"}, 32'(lit_wr_addr), 32'(exp_addr));
    check({tag, "_data"}, 32'(lit_wr_data), 32'(exp_data));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start_solve = 1'b1;
    step();
    start_solve = 1'b0;
  endtask

  initial begin
    int           lits [6];
    logic         ces  [6];
    logic [VW:0]  dats [6];
    int           k;

    lits = '{1, -2, 2, 3, -1, -3};
    ces  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    dats = '{9'h000, 9'h101, 9'h001, 9'h002, 9'h100, 9'h102};

    rst = 1'b1; clear = 1'b0; load_valid = 1'b0; load_literal = '0;
    load_clause_end = 1'b0; start_solve = 1'b0;
    repeat (4) step();
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_lit_en", 32'(lit_wr_en), 32'd0);
    check("rst_nlits", 32'(num_lits), 32'd0);
    check("rst_ncls", 32'(num_clauses), 32'd0);
    check("rst_err", 32'(error_code), 32'd0);
    rst = 1'b0;
    step();
    check("load_ready_up", 32'(load_ready), 32'd1);

    // three two-literal clauses, then start
    for (int i = 0; i < 6; i++) begin
      send_chk("basic", lits[i], ces[i], i, dats[i]);
      if (ces[i]) begin
        check("basic_cls_en", 32'(cls_wr_en), 32'd1);
        check("basic_cls_addr", 32'(cls_wr_addr), 32'(i / 2));
        check("basic_cls_start", 32'(cls_wr_start), 32'(i - 1));
        check("basic_cls_len", 32'(cls_wr_len), 32'd2);
      end else begin
        check("basic_cls_idle", 32'(cls_wr_en), 32'd0);
      end
    end
    check("basic_ncls", 32'(num_clauses), 32'd3);
    check("basic_nlits", 32'(num_lits), 32'd6);
    check("basic_maxvar", 32'(max_var), 32'd3);
    pulse_start();
    check("basic_go", 32'(solve_go), 32'd1);
    check("locked_ready", 32'(load_ready), 32'd0);
    step();
    check("go_single", 32'(solve_go), 32'd0);
    pulse_start();
    check("locked_start_ignored", 32'(solve_go), 32'd0);

    // final literal with clause end plus start in one cycle
    do_clear();
    send(5, 1'b0);
    load_valid = 1'b1; load_literal = 6; load_clause_end = 1'b1; start_solve = 1'b1;
    step();
    load_valid = 1'b0; load_clause_end = 1'b0; start_solve = 1'b0;
    check("same_cls_en", 32'(cls_wr_en), 32'd1);
    check("same_cls_len", 32'(cls_wr_len), 32'd2);
    check("same_cls_start", 32'(cls_wr_start), 32'd0);
    check("same_go", 32'(solve_go), 32'd1);
    check("same_noerr", 32'(load_error), 32'd0);
    check("same_maxvar", 32'(max_var), 32'd6);

    // literal validation errors
    do_clear();
    send(0, 1'b0);
    check("zero_en", 32'(lit_wr_en), 32'd0);
    check("zero_code", 32'(error_code), 32'd1);
    check("zero_flag", 32'(load_error), 32'd1);
    check("zero_ready", 32'(load_ready), 32'd0);
    send(4, 1'b1);
    check("err_ignore_en", 32'(lit_wr_en), 32'd0);
    check("err_ignore_nlits", 32'(num_lits), 32'd0);
    check("err_sticky", 32'(error_code), 32'd1);

    do_clear();
    send(257, 1'b0);
    check("big_en", 32'(lit_wr_en), 32'd0);
    check("big_code", 32'(error_code), 32'd2);

    do_clear();
    send(32'sh8000_0000, 1'b0);
    check("minint_en", 32'(lit_wr_en), 32'd0);
    check("minint_code", 32'(error_code), 32'd2);
    check("minint_ready", 32'(load_ready), 32'd0);

    // clause length limit
    do_clear();
    for (int i = 1; i <= 16; i++)
      send_chk("len16", i, 1'b0, i - 1, 9'(i - 1));
    send(17, 1'b0);
    check("len17_en", 32'(lit_wr_en), 32'd0);
    check("len17_code", 32'(error_code), 32'd5);
    check("len17_nlits", 32'(num_lits), 32'd16);

    // start with an open clause, and with nothing loaded
    do_clear();
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    pulse_start();
    check("open_code", 32'(error_code), 32'd6);
    check("open_go", 32'(solve_go), 32'd0);
    check("open_flag", 32'(load_error), 32'd1);

    do_clear();
    pulse_start();
    check("empty_code", 32'(error_code), 32'd7);
    check("empty_go", 32'(solve_go), 32'd0);

    // fill literal memory exactly: 128 clauses of 16
    do_clear();
    for (int c = 0; c < 128; c++) begin
      for (int j = 0; j < 16; j++) begin
        k = c * 16 + j;
        send((k % 200) + 1, (j == 15));
        check("fill_wr", {20'd0, lit_wr_en, lit_wr_addr}, {20'd0, 1'b1, 11'(k)});
      end
    end
    check("fill_cls_addr", 32'(cls_wr_addr), 32'd127);
    check("fill_cls_start", 32'(cls_wr_start), 32'd2032);
    check("fill_cls_len", 32'(cls_wr_len), 32'd16);
    check("fill_nlits", 32'(num_lits), 32'd2048);
    check("fill_ncls", 32'(num_clauses), 32'd128);
    check("fill_maxvar", 32'(max_var), 32'd200);
    check("fill_noerr", 32'(load_error), 32'd0);
    send(5, 1'b1);
    check("over_en", 32'(lit_wr_en), 32'd0);
    check("over_code", 32'(error_code), 32'd3);
    check("over_nlits", 32'(num_lits), 32'd2048);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_nlits", 32'(num_lits), 32'd0);
    check("clr_ncls", 32'(num_clauses), 32'd0);
    check("clr_code", 32'(error_code), 32'd0);
    check("clr_maxvar", 32'(max_var), 32'd0);
    check("clr_init_ready", 32'(load_ready), 32'd0);
    step();
    check("clr_load_ready", 32'(load_ready), 32'd1);

    // rst while locked, then rst mid-clause, then reload
    send(1, 1'b1);
    pulse_start();
    check("pre_rst_go", 32'(solve_go), 32'd1);
    rst = 1'b1;
    step();
    check("rstl_go", 32'(solve_go), 32'd0);
    check("rstl_ncls", 32'(num_clauses), 32'd0);
    check("rstl_nlits", 32'(num_lits), 32'd0);
    check("rstl_maxvar", 32'(max_var), 32'd0);
    check("rstl_cls_en", 32'(cls_wr_en), 32'd0);
    check("rstl_ready", 32'(load_ready), 32'd0);
    rst = 1'b0;
    step();
    send(3, 1'b0);
    rst = 1'b1;
    step();
    check("rstm_lit_en", 32'(lit_wr_en), 32'd0);
    check("rstm_addr", 32'(lit_wr_addr), 32'd0);
    check("rstm_nlits", 32'(num_lits), 32'd0);
    rst = 1'b0;
    step();
    send_chk("reload", 1, 1'b1, 0, 9'h000);
    check("reload_cls_en", 32'(cls_wr_en), 32'd1);
    check("reload_cls_start", 32'(cls_wr_start), 32'd0);
    check("reload_cls_len", 32'(cls_wr_len), 32'd1);
    pulse_start();
    check("reload_go", 32'(solve_go), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clause_loader.md
Name: clause_loader

Overview:
- Receiving end of the host clause-load stream.
- Accepts signed DIMACS literals one per handshake, with an end-of-clause flag.
- Validates each literal, writes it into the solver literal memory and writes one clause-table entry (start, length) per clause.
- Gates the solve-start request and sits between the host port of mini_top and the DPLL solver's clause/literal stores.

Parameters:
- MAX_VARS, 256: highest legal variable index; variables are 1..MAX_VARS.
- MAX_CLAUSES, 256: clause-table depth.
- MAX_LITS, 2048: literal-memory depth.
- MAX_CLAUSE_LEN, 16: maximum literals per clause.
- Derived: VW=$clog2(MAX_VARS), LAW=$clog2(MAX_LITS), CAW=$clog2(MAX_CLAUSES), LNW=$clog2(MAX_CLAUSE_LEN+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clear  in  1  one-cycle pulse: discard loaded problem, return to LOAD
- load_valid  in  1  host literal valid
- load_literal  in  32  signed DIMACS literal
- load_clause_end  in  1  literal is last of its clause
- load_ready  out  1  loader can accept a literal
- start_solve  in  1  host start request (pulse)
- lit_wr_en  out  1  literal memory write strobe
- lit_wr_addr  out  LAW  literal memory address
- lit_wr_data  out  1+VW  {neg, var-1}
- cls_wr_en  out  1  clause table write strobe
- cls_wr_addr  out  CAW  clause index
- cls_wr_start  out  LAW  first-literal address of clause
- cls_wr_len  out  LNW  clause length
- num_clauses  out  CAW+1  committed clauses
- num_lits  out  LAW+1  committed literals
- max_var  out  VW+1  largest variable index seen
- solve_go  out  1  one-cycle pulse to solver core
- load_error  out  1  sticky error flag
- error_code  out  3  first error cause

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Priority: rst > clear > all other inputs. Both rst and clear zero every counter, error_code and max_var, and put the FSM in INIT.
- Reset values: all outputs 0; load_ready=0.
- States:
  - INIT: one cycle, load_ready=0, then go to LOAD.
  - LOAD: load_ready=1.
  - LOCKED: problem handed to the solver, load_ready=0.
  - ERROR: load_ready=0.
  - LOCKED and ERROR leave only on rst or clear.
- Transfer: occurs on a cycle with load_valid & load_ready. load_valid without load_ready is ignored; nothing is buffered.
- Per transfer, all writes are registered (outputs valid the cycle after the transfer; 1-cycle latency):
  - lit_wr_en=1, lit_wr_addr=num_lits.
  - lit_wr_data={literal<0, |literal|-1}.
  - num_lits increments; cur_len increments.
  - max_var=max(max_var, |literal|).
- Clause end: on a transfer with load_clause_end=1, the same registered cycle also drives:
  - cls_wr_en=1, cls_wr_addr=num_clauses, cls_wr_start=clause base address, cls_wr_len=cur_len+1.
  - num_clauses increments; the base address moves to the next literal; cur_len resets to 0.
- Validation runs in the transfer cycle, before any write. On the first error: suppress all writes for that literal, latch error_code, set load_error, go to ERROR. Error codes:
  - 1: literal==0.
  - 2: |literal|>MAX_VARS. Use a 32-bit magnitude; -2^31 maps to code 2.
  - 3: num_lits==MAX_LITS (literal memory full).
  - 4: clause end with num_clauses==MAX_CLAUSES.
  - 5: cur_len==MAX_CLAUSE_LEN and another literal arrives.
  - 6: start_solve while a clause is open (cur_len!=0 after this cycle's transfer).
  - 7: start_solve with num_clauses==0 after this cycle's transfer.
  - Several codes in one cycle: the lowest code wins.
- Boundaries:
  - Exactly MAX_LITS literals is legal.
  - A MAX_CLAUSE_LEN-length clause is legal.
  - Memory addresses never wrap.
- start_solve in LOAD:
  - Evaluated after the same-cycle transfer; a final literal with clause_end plus start in one cycle is legal.
  - Legal: next cycle solve_go=1 for exactly one cycle and state=LOCKED.
  - Illegal: go to ERROR (code 6 or 7); no solve_go.
- start_solve in INIT, LOCKED or ERROR is ignored.
- clear or rst mid-clause discards the partial clause. No write strobe fires in the cycle after clear or rst.
- Memory contents are not erased. Consumers use num_clauses/num_lits as valid bounds.

Test Plan:
- Reset 4 cycles, load clauses {1,-2},{2,3},{-1,-3}, then start:
  - literal writes at addresses 0..5 with data {0,0},{1,1},{0,1},{0,2},{1,0},{1,2}.
  - clause entries (0,0,2),(1,2,2),(2,4,2).
  - num_clauses=3, num_lits=6, max_var=3; one solve_go pulse; load_ready=0 afterwards.
- Last literal with clause_end and start_solve in the same cycle -> clause committed and solve_go the next cycle, with no error.
- Literal 0 -> code 1. Literal 257 (with MAX_VARS=256) -> code 2. Literal -2147483648 -> code 2. In each case: no write strobe, load_ready=0 thereafter, further valid literals ignored.
- 17-literal clause (MAX_CLAUSE_LEN=16) -> literals 1..16 written, 17th rejected with code 5. Start with a 3-literal open clause -> code 6, no solve_go.
- Fill to MAX_LITS=2048 exactly (128 clauses × 16) -> all accepted. 2049th literal -> code 3. Then clear -> counts 0, INIT then LOAD, load_ready=1 after 2 cycles.
- rst pulse while in LOCKED and mid-clause while in LOAD -> all outputs 0 the next cycle; reload of {1} succeeds with cls_wr_start=0.
